// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the FSM state encoding and the two PC increment sizes.
// Imported by pc_next_sel and pc_sequencer; the PC_RVC_EN macro is not used here.
package pc_pkg;

  // The encoding is visible on state_out, so the values are fixed.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int PC_INC_W = 4;  // 32-bit instruction
  localparam int PC_INC_C = 2;  // 16-bit compressed instruction

endpackage : pc_pkg

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority mux with redirect-target alignment check.
// Ports: state/pc_q/accept come from pc_sequencer; trap_req, redirect_*, halt_req and
//   instr_is_c (PC_RVC_EN builds only) come from control; pc_next and misalign_next are its outputs.
// Macro PC_RVC_EN: 2/4-byte increment and halfword alignment; otherwise a fixed 4-byte increment and word alignment.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'('h100)
) (
  input  pc_state_e         state,
  input  logic [XLEN-1:0]   pc_q,
  input  logic              trap_req,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              halt_req,
  input  logic              accept,
`ifdef PC_RVC_EN
  input  logic              instr_is_c,
`endif
  output logic [XLEN-1:0]   pc_next,
  output logic              misalign_next
);

  logic            target_ok;
  logic [XLEN-1:0] inc;

`ifdef PC_RVC_EN
  assign target_ok = (redirect_target[0] == 1'b0);
  assign inc       = instr_is_c ? XLEN'(PC_INC_C) : XLEN'(PC_INC_W);
`else
  assign target_ok = (redirect_target[1:0] == 2'b00);
  assign inc       = XLEN'(PC_INC_W);
`endif

  always_comb begin
    pc_next       = pc_q;
    misalign_next = 1'b0;
    case (state)
      RUN: begin
        if (trap_req) begin
          pc_next = TRAP_VEC;
        end else if (redirect_valid) begin
          // A rejected target vectors to the trap handler rather than fetching garbage.
          pc_next       = target_ok ? redirect_target : TRAP_VEC;
          misalign_next = !target_ok;
        end else if (halt_req) begin
          pc_next = pc_q;
        end else if (accept) begin
          // Plain modular add: the PC wraps silently past the top of the address space.
          pc_next = pc_q + inc;
        end
      end
      HALT: begin
        if (trap_req) begin
          pc_next = TRAP_VEC;
        end else if (redirect_valid) begin
          pc_next       = target_ok ? redirect_target : TRAP_VEC;
          misalign_next = !target_ok;
        end
      end
      default: begin
        pc_next = pc_q;
      end
    endcase
  end

endmodule : pc_next_sel

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address register with BOOT/RUN/HALT FSM, valid/ready fetch handshake,
//   trap/redirect handling, misalign pulse and an accepted-fetch counter.
// Ports: clk/rst (sync, active-high); stall, redirect_*, trap_req, halt_req, resume, fetch_ready,
//   instr_is_c (PC_RVC_EN only) in; pc_out, fetch_valid, misalign, state_out, fetch_cnt out.
// Macro PC_RVC_EN enables compressed-instruction stepping; fetch_valid is combinational from state and stall.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
  parameter int              CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              trap_req,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              fetch_ready,
`ifdef PC_RVC_EN
  input  logic              instr_is_c,
`endif
  output logic [XLEN-1:0]   pc_out,
  output logic              fetch_valid,
  output logic              misalign,
  output logic [1:0]        state_out,
  output logic [CNT_W-1:0]  fetch_cnt
);

  pc_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign fetch_valid = (state_q == RUN) && !stall;
  assign accept      = fetch_valid && fetch_ready;

  pc_next_sel #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_next_sel (
    .state           (state_q),
    .pc_q            (pc_q),
    .trap_req        (trap_req),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .accept          (accept),
`ifdef PC_RVC_EN
    .instr_is_c      (instr_is_c),
`endif
    .pc_next         (pc_d),
    .misalign_next   (misalign_d)
  );

  // Next-state logic. Trap and redirect outrank halt in RUN; trap also pulls HALT back to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!trap_req && !redirect_valid && halt_req) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (trap_req || resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // The counter follows the handshake alone, even when a redirect or trap wins the PC.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_out    = pc_q;
  assign misalign  = misalign_q;
  assign state_out = state_q;
  assign fetch_cnt = cnt_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 64-bit and a 32-bit instance share all inputs.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that point.
// Builds with or without PC_RVC_EN; the misaligned-redirect expectation follows the macro.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, trap_req, halt_req, resume, fetch_ready;
  logic        instr_is_c;
  logic [63:0] redirect_target;

  logic [63:0] pc64;
  logic        fv64, mis64;
  logic [1:0]  st64;
  logic [31:0] cnt64;

  logic [31:0] pc32;
  logic        fv32, mis32;
  logic [1:0]  st32;
  logic [31:0] cnt32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(64)) dut64 (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_req        (trap_req),
    .halt_req        (halt_req),
    .resume          (resume),
    .fetch_ready     (fetch_ready),
`ifdef PC_RVC_EN
    .instr_is_c      (instr_is_c),
`endif
    .pc_out          (pc64),
    .fetch_valid     (fv64),
    .misalign        (mis64),
    .state_out       (st64),
    .fetch_cnt       (cnt64)
  );

  pc_sequencer #(.XLEN(32)) dut32 (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target[31:0]),
    .trap_req        (trap_req),
    .halt_req        (halt_req),
    .resume          (resume),
    .fetch_ready     (fetch_ready),
`ifdef PC_RVC_EN
    .instr_is_c      (instr_is_c),
`endif
    .pc_out          (pc32),
    .fetch_valid     (fv32),
    .misalign        (mis32),
    .state_out       (st32),
    .fetch_cnt       (cnt32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_ready = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (st64 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", st64); end
    checks++; if (pc64 !== 64'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc64); end
    checks++; if (fv64 !== 1'b0 || mis64 !== 1'b0) begin errors++; $display("FAIL reset_valid_mis got %b%b exp 00", fv64, mis64); end
    checks++; if (cnt64 !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt64); end
    tick();
    checks++; if (st64 !== 2'd1 || fv64 !== 1'b1 || pc64 !== 64'h0) begin errors++; $display("FAIL boot_to_run st=%0d fv=%b pc=%h exp 1 1 0", st64, fv64, pc64); end
    tick();
    checks++; if (pc64 !== 64'h4) begin errors++; $display("FAIL seq_pc4 got %h exp 4", pc64); end
    tick();
    checks++; if (pc64 !== 64'h8 || cnt64 !== 32'd2) begin errors++; $display("FAIL seq_pc8 pc=%h cnt=%0d exp 8 2", pc64, cnt64); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    checks++; if (fv64 !== 1'b0) begin errors++; $display("FAIL stall_valid got %b exp 0", fv64); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc64 !== 64'h8 || cnt64 !== 32'd2 || fv64 !== 1'b0) begin errors++; $display("FAIL stall_hold%0d pc=%h cnt=%0d fv=%b exp 8 2 0", i, pc64, cnt64, fv64); end
    end
    stall = 1'b0;
    tick();
    checks++; if (pc64 !== 64'hC || cnt64 !== 32'd3) begin errors++; $display("FAIL stall_release pc=%h cnt=%0d exp c 3", pc64, cnt64); end
  endtask

  task automatic test_redirect();
    logic [63:0] exp_pc;
    logic        exp_mis;
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 64'h40;
    tick();
    stall = 1'b0;
    checks++; if (pc64 !== 64'h40 || mis64 !== 1'b0 || cnt64 !== 32'd3) begin errors++; $display("FAIL redir_stall pc=%h mis=%b cnt=%0d exp 40 0 3", pc64, mis64, cnt64); end
    // Accept in the same cycle as the redirect still counts.
    redirect_target = 64'h42;
    tick();
    redirect_valid = 1'b0; fetch_ready = 1'b0;
`ifdef PC_RVC_EN
    exp_pc = 64'h42; exp_mis = 1'b0;
`else
    exp_pc = 64'h100; exp_mis = 1'b1;
`endif
    checks++; if (pc64 !== exp_pc || mis64 !== exp_mis) begin errors++; $display("FAIL redir_42 pc=%h mis=%b exp %h %b", pc64, mis64, exp_pc, exp_mis); end
    checks++; if (cnt64 !== 32'd4) begin errors++; $display("FAIL redir_cnt got %0d exp 4", cnt64); end
    tick();
    checks++; if (mis64 !== 1'b0 || pc64 !== exp_pc) begin errors++; $display("FAIL mis_pulse mis=%b pc=%h exp 0 %h", mis64, pc64, exp_pc); end
  endtask

  task automatic test_trap_halt();
    trap_req = 1'b1; redirect_valid = 1'b1; redirect_target = 64'h43;
    tick();
    trap_req = 1'b0; redirect_valid = 1'b0;
    checks++; if (pc64 !== 64'h100 || mis64 !== 1'b0) begin errors++; $display("FAIL trap_wins pc=%h mis=%b exp 100 0", pc64, mis64); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0; fetch_ready = 1'b1;
    checks++; if (st64 !== 2'd2 || fv64 !== 1'b0 || pc64 !== 64'h100) begin errors++; $display("FAIL halt_enter st=%0d fv=%b pc=%h exp 2 0 100", st64, fv64, pc64); end
    tick(); tick();
    checks++; if (st64 !== 2'd2 || pc64 !== 64'h100 || cnt64 !== 32'd4) begin errors++; $display("FAIL halt_hold st=%0d pc=%h cnt=%0d exp 2 100 4", st64, pc64, cnt64); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++; if (st64 !== 2'd1 || fv64 !== 1'b1 || pc64 !== 64'h100) begin errors++; $display("FAIL resume st=%0d fv=%b pc=%h exp 1 1 100", st64, fv64, pc64); end
    tick();
    checks++; if (pc64 !== 64'h104 || cnt64 !== 32'd5) begin errors++; $display("FAIL post_resume pc=%h cnt=%0d exp 104 5", pc64, cnt64); end
  endtask

  task automatic test_wrap_and_reset();
    redirect_valid = 1'b1; redirect_target = 64'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    checks++; if (pc32 !== 32'hFFFF_FFFC || cnt32 !== 32'd6) begin errors++; $display("FAIL wrap_setup pc32=%h cnt=%0d exp fffffffc 6", pc32, cnt32); end
    tick();
    checks++; if (pc32 !== 32'h0 || cnt32 !== 32'd7) begin errors++; $display("FAIL wrap32 pc32=%h cnt=%0d exp 0 7", pc32, cnt32); end
    checks++; if (pc64 !== 64'h1_0000_0000) begin errors++; $display("FAIL nowrap64 pc=%h exp 100000000", pc64); end
    fetch_ready = 1'b0; halt_req = 1'b1;
    tick();
    halt_req = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h200;
    tick();
    redirect_valid = 1'b0;
    checks++; if (st64 !== 2'd2 || pc64 !== 64'h200) begin errors++; $display("FAIL halt_redirect st=%0d pc=%h exp 2 200", st64, pc64); end
    trap_req = 1'b1; resume = 1'b1;
    tick();
    trap_req = 1'b0; resume = 1'b0;
    checks++; if (st64 !== 2'd1 || pc64 !== 64'h100) begin errors++; $display("FAIL halt_trap st=%0d pc=%h exp 1 100", st64, pc64); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0; rst = 1'b1;
    checks++; if (st32 !== 2'd2) begin errors++; $display("FAIL halt_again st=%0d exp 2", st32); end
    tick();
    rst = 1'b0;
    checks++; if (st32 !== 2'd0 || pc32 !== 32'h0 || cnt32 !== 32'd0 || fv32 !== 1'b0) begin errors++; $display("FAIL rst_in_halt st=%0d pc=%h cnt=%0d fv=%b exp 0 0 0 0", st32, pc32, cnt32, fv32); end
    checks++; if (st64 !== 2'd0 || pc64 !== 64'h0 || cnt64 !== 32'd0) begin errors++; $display("FAIL rst_in_halt64 st=%0d pc=%h cnt=%0d exp 0 0 0", st64, pc64, cnt64); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    trap_req = 1'b0; halt_req = 1'b0; resume = 1'b0; fetch_ready = 1'b0; instr_is_c = 1'b0;
    #2;
    test_reset();
    test_stall();
    test_redirect();
    test_trap_halt();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pc_sequencer
